// File: rtl/spr_nested.sv
// spr_nested
// ----------
// Special-purpose register file for the interrupt unit. It holds SR, ESR,
// ECA, EPC, EDATA and a STATUS word. A jisr pulse saves the interrupted
// context, and an rfe pulse restores it. A hardware save stack of NEST_DEPTH
// entries keeps outer exception contexts alive, so a handler can re-enable
// interrupts and take a nested interrupt without losing the outer context.
//
// Ports:
//   clk, reset   rising-edge clock and synchronous active-high reset
//   jisr         capture the interrupted context and push the old one
//   rfe          return from exception: SR <- ESR, pop the saved context
//   mca          masked cause vector, captured into ECA
//   rpt          1 = EPC gets pc (repeat), 0 = EPC gets next_pc
//   pc, next_pc  PC of the interrupted instruction and of its successor
//   ea           effective address of the faulting access, captured into EDATA
//   data_in      movi2s write data
//   reg_sel      register select for read and write
//                (0 SR, 1 ESR, 2 ECA, 3 EPC, 5 EDATA, 6 STATUS)
//   sprw         write enable for data_in into reg_sel
//   spr_out      combinational read of reg_sel
//   sr_out       live SR (interrupt mask)
//   epc_out      live EPC (rfe jump target)
//   nest_depth   number of occupied stack entries
//   nest_ovf     sticky flag, set when a jisr finds the stack full
module spr_nested #(
  parameter int DATA_W     = 32,
  parameter int CAUSE_W    = 23,
  parameter int NEST_DEPTH = 4,
  parameter int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jisr,
  input  logic               rfe,
  input  logic [CAUSE_W-1:0] mca,
  input  logic               rpt,
  input  logic [DATA_W-1:0]  pc,
  input  logic [DATA_W-1:0]  next_pc,
  input  logic [DATA_W-1:0]  ea,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [2:0]         reg_sel,
  input  logic               sprw,
  output logic [DATA_W-1:0]  spr_out,
  output logic [DATA_W-1:0]  sr_out,
  output logic [DATA_W-1:0]  epc_out,
  output logic [DEPTH_W-1:0] nest_depth,
  output logic               nest_ovf
);

  // One saved context is {ESR, ECA, EPC, EDATA}.
  localparam int ENTRY_W = 3 * DATA_W + CAUSE_W;
  localparam int IDX_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NEST_DEPTH);

  logic [DATA_W-1:0]  sr;
  logic [DATA_W-1:0]  esr;
  logic [CAUSE_W-1:0] eca;
  logic [DATA_W-1:0]  epc;
  logic [DATA_W-1:0]  edata;
  logic [DEPTH_W-1:0] depth;
  logic               ovf;

  // Stack storage has no reset. Clearing the depth is enough to discard
  // its contents.
  logic [ENTRY_W-1:0] stack [NEST_DEPTH];

  logic               stack_full;
  logic               stack_empty;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;
  logic [ENTRY_W-1:0] live_ctx;
  logic [DATA_W-1:0]  status_word;

  // Stack addressing. A push writes entry 'depth', and a pop reads entry
  // 'depth-1'. The out-of-range cases (push when full, pop when empty) are
  // gated by stack_full and stack_empty, so the truncated indices are only
  // used when they are valid.
  always_comb begin
    stack_full  = (depth >= DEPTH_MAX);
    stack_empty = (depth == '0);
    push_idx    = IDX_W'(depth);
    pop_idx     = IDX_W'(depth - DEPTH_W'(1));
    live_ctx    = {esr, eca, epc, edata};
  end

  // STATUS word: the sticky overflow flag is in the MSB, and the depth
  // counter is in the low bits.
  always_comb begin
    status_word              = '0;
    status_word[DEPTH_W-1:0] = depth;
    status_word[DATA_W-1]    = ovf;
  end

  // Architectural register update. Only the highest-priority event of the
  // cycle acts (reset > jisr > rfe > sprw), and lower ones are dropped.
  // On jisr the capture always happens, even when the push overflows, so the
  // oldest saved contexts survive and the newest live one is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      esr   <= '0;
      eca   <= '0;
      epc   <= '0;
      edata <= '0;
      depth <= '0;
      ovf   <= 1'b0;
    end else if (jisr) begin
      if (stack_full) begin
        ovf <= 1'b1;
      end else begin
        depth <= depth + DEPTH_W'(1);
      end
      esr   <= sr;
      sr    <= '0;
      eca   <= mca;
      epc   <= rpt ? pc : next_pc;
      edata <= ea;
    end else if (rfe) begin
      sr <= esr;
      if (!stack_empty) begin
        {esr, eca, epc, edata} <= stack[pop_idx];
        depth <= depth - DEPTH_W'(1);
      end
    end else if (sprw) begin
      case (reg_sel)
        3'd0: sr    <= data_in;
        3'd1: esr   <= data_in;
        3'd2: eca   <= data_in[CAUSE_W-1:0];
        3'd3: epc   <= data_in;
        3'd5: edata <= data_in;
        3'd6: if (data_in[DATA_W-1]) ovf <= 1'b0;
        default: ;
      endcase
    end
  end

  // Save-stack write port. Only a jisr that finds room stores the pre-edge
  // live context. No other event writes the stack.
  always_ff @(posedge clk) begin
    if (!reset && jisr && !stack_full) begin
      stack[push_idx] <= live_ctx;
    end
  end

  // Zero-latency read mux. This path has no bypass, so a same-cycle write is
  // not visible until the next cycle.
  always_comb begin
    case (reg_sel)
      3'd0:    spr_out = sr;
      3'd1:    spr_out = esr;
      3'd2:    spr_out = DATA_W'(eca);
      3'd3:    spr_out = epc;
      3'd5:    spr_out = edata;
      3'd6:    spr_out = status_word;
      default: spr_out = '0;
    endcase
  end

  // Live outputs.
  always_comb begin
    sr_out     = sr;
    epc_out    = epc;
    nest_depth = depth;
    nest_ovf   = ovf;
  end

endmodule

// File: doc/spr_nested.md
# spr_nested

Parametrised special-purpose register file for the interrupt unit of the MIPS core, with a hardware save stack for nested interrupts. Holds SR, ESR, ECA, EPC, EDATA and a status word, captures the interrupted context on `jisr`, and restores it on `rfe`. Each `jisr` pushes the previous exception context onto a `NEST_DEPTH`-deep stack, so a handler can re-enable interrupts without losing the outer context. Sits between the cause/interrupt logic (`mca`, `jisr`) and the register-move datapath (`data_in`, `spr_out`).

## Interface
Parameters:
- `DATA_W`, 32: width of SR, ESR, EPC, EDATA, `data_in` and `spr_out`.
- `CAUSE_W`, 23: width of ECA and `mca`. Must satisfy `CAUSE_W <= DATA_W`.
- `NEST_DEPTH`, 4: number of save-stack entries. Must be at least 1.
- `DEPTH_W`, `$clog2(NEST_DEPTH+1)`: width of the depth counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `jisr`  in  1  jump-to-interrupt-service pulse; capture context.
- `rfe`  in  1  return-from-exception pulse.
- `mca`  in  CAUSE_W  masked cause vector.
- `rpt`  in  1  repeat: 1 = re-execute the interrupted instruction.
- `pc`  in  DATA_W  PC of the interrupted instruction.
- `next_pc`  in  DATA_W  PC of the following instruction.
- `ea`  in  DATA_W  effective address of the faulting access.
- `data_in`  in  DATA_W  movi2s write data.
- `reg_sel`  in  3  register select for read and write.
- `sprw`  in  1  write enable for `data_in` into `reg_sel`.
- `spr_out`  out  DATA_W  combinational read of `reg_sel`.
- `sr_out`  out  DATA_W  live SR (interrupt mask).
- `epc_out`  out  DATA_W  live EPC (rfe jump target).
- `nest_depth`  out  DEPTH_W  number of occupied stack entries.
- `nest_ovf`  out  1  sticky overflow flag.

## Operation
- `reg_sel` map: 0 SR, 1 ESR, 2 ECA, 3 EPC, 5 EDATA, 6 STATUS.
  - STATUS = {`nest_ovf` at bit DATA_W-1, zeros, `nest_depth` at bits DEPTH_W-1:0}.
  - Selects 4 and 7 read 0. Writes to 4 and 7 are ignored.
- ECA reads zero-extended. A write to ECA stores `data_in[CAUSE_W-1:0]`.
- A write to STATUS clears `nest_ovf` if `data_in[DATA_W-1]` is 1. `nest_depth` is not writable.
- Live context is {ESR, ECA, EPC, EDATA}. A stack entry holds one context: 3·DATA_W+CAUSE_W bits.
- Per cycle, events take effect in priority order: `reset` > `jisr` > `rfe` > `sprw`. Lower-priority events in the same cycle are dropped entirely.
- `jisr`:
  - Push: if `nest_depth < NEST_DEPTH`, write the current live context to entry `nest_depth` and increment the depth. Otherwise there is no push and `nest_ovf` is set to 1; the stack contents are untouched.
  - Capture: ESR ← SR, SR ← 0, ECA ← `mca`, EPC ← `rpt ? pc : next_pc`, EDATA ← `ea`.
  - The capture happens whether or not the push succeeded, so on overflow the oldest saved contexts are kept and the live context is lost.
- `rfe`:
  - SR ← ESR, using the pre-edge value.
  - If `nest_depth > 0`: restore the live context from entry `nest_depth-1` and decrement the depth.
  - If `nest_depth == 0`: the live context is unchanged. This is not an error.
  - `nest_ovf` is unaffected.
- `sprw` alone: writes the selected register only. It never touches the stack.
- Stack entries are never cleared; entries at index ≥ `nest_depth` are don't-care.

## Timing
- Reset: SR, ESR, ECA, EPC, EDATA = 0; `nest_depth` = 0; `nest_ovf` = 0. Hence `spr_out`, `sr_out` and `epc_out` are 0 after reset. Reset asserted mid-nesting discards all stack contents.
- `spr_out`, `sr_out`, `epc_out`, `nest_depth` and `nest_ovf` are combinational from registered state, with zero-latency read.
- A write or capture in cycle N is visible from cycle N+1. There is no read-during-write bypass: a same-cycle read returns the old value.
- The core samples `epc_out` in the `rfe` cycle, i.e. before the pop takes effect.
- Back-to-back `jisr` on consecutive cycles pushes once per cycle. Back-to-back `rfe` pops once per cycle.
- Single-cycle operations only; there is no handshake and no stall.

## Test plan
- Reset, then `sprw`: write SR=0xCCCCCCCC, ESR=0x00FF00FF, ECA=0xFFFFFFFF. Read back 0xCCCCCCCC, 0x00FF00FF, 0x007FFFFF; STATUS=0.
- Capture: with SR=0xAAAAAAAA, `jisr` with `mca`=0x6AAAAA, `rpt`=1, `pc`=0xF0F0F0F0, `next_pc`=0xFF00FF00, `ea`=0x0F0FF0F0. Expect SR=0, ESR=0xAAAAAAAA, ECA=0x6AAAAA, EPC=0xF0F0F0F0, EDATA=0x0F0FF0F0, depth=1. Repeat with `rpt`=0: EPC=0xFF00FF00.
- Nesting: SR=0x1, then `jisr` (`pc`=0x100, `rpt`=1), write SR=0x3, `jisr` (`pc`=0x200, `rpt`=1). Expect depth=2, EPC=0x200, ESR=0x3. After `rfe`: SR=0x3, EPC=0x100, ESR=0x1, depth=1. After a second `rfe`: SR=0x1, depth=0.
- Overflow (`NEST_DEPTH`=4): 5 `jisr` pulses with `pc`=1..5. Expect depth=4, `nest_ovf`=1, STATUS=0x80000004. Then 4 `rfe` pulses restore EPC values 3, 2, 1, 0 in order. Writing STATUS with 0x80000000 clears `nest_ovf`.
- Collisions: `jisr`+`rfe`+`sprw` (`reg_sel`=0, `data_in`=0xDEADBEEF) in one cycle. Only the `jisr` takes effect: SR=0, depth increments by 1. `rfe` at depth 0: SR ← ESR, other registers unchanged, depth stays 0.
- Reset mid-nesting at depth=3: the next cycle shows all outputs 0; a subsequent `rfe` leaves EPC=0 and depth=0.
